// File: rtl/led_pixel_fetch.sv
// Per-LED pixel fetch: accepts selector indices, reads frame RAM, emits GRB pixel words 2 edges later.
// Optional global brightness scaling with `LED_BRIGHTNESS_SCALE_EN`.
module led_pixel_fetch #(
  parameter int NUM_LEDS   = 150,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  led_clock,
  input  logic                  led_counter_reset,
  input  logic [ADDR_WIDTH-1:0] led_counter,
  input  logic                  index_valid,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [23:0]           ram_rdata,
`ifdef LED_BRIGHTNESS_SCALE_EN
  input  logic [7:0]            brightness,
`endif
  output logic [23:0]           pixel_data,
  output logic                  pixel_valid,
  output logic [ADDR_WIDTH-1:0] pixel_index,
  output logic                  frame_done,
  output logic [7:0]            pixel_count,
  output logic                  seq_error,
  output logic                  range_error
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_LEDS - 1);

  logic                  idx_seen;
  logic                  s0_valid;
  logic                  s1_valid;
  logic [ADDR_WIDTH-1:0] s1_index;
  logic [23:0]           s1_rgb;
  logic                  in_range;
  logic                  accept;
  logic                  seq_break;
  logic [23:0]           grb;

`ifdef LED_BRIGHTNESS_SCALE_EN
  logic [7:0] s1_bright;

  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
    logic [16:0] p;
    p = {9'd0, c} * ({9'd0, b} + 17'd1);
    return 8'(p >> 8);
  endfunction
`endif

  // ram_addr only moves on accept, so it doubles as the last accepted index
  always_comb begin
    in_range  = (led_counter <= LAST_IDX);
    accept    = index_valid && in_range && (!idx_seen || (led_counter != ram_addr));
    seq_break = idx_seen && (led_counter != (ram_addr - ADDR_WIDTH'(1)));
  end

  always_ff @(posedge led_clock or posedge led_counter_reset) begin
    if (led_counter_reset) begin
      ram_addr    <= '0;
      s0_valid    <= 1'b0;
      idx_seen    <= 1'b0;
      seq_error   <= 1'b0;
      range_error <= 1'b0;
    end else begin
      s0_valid <= accept;
      if (accept) begin
        ram_addr <= led_counter;
        idx_seen <= 1'b1;
        if (seq_break) seq_error <= 1'b1;
      end
      if (index_valid && !in_range) range_error <= 1'b1;
    end
  end

  always_ff @(posedge led_clock or posedge led_counter_reset) begin
    if (led_counter_reset) begin
      s1_valid  <= 1'b0;
      s1_index  <= '0;
      s1_rgb    <= '0;
`ifdef LED_BRIGHTNESS_SCALE_EN
      s1_bright <= '0;
`endif
    end else begin
      s1_valid <= s0_valid;
      if (s0_valid) begin
        s1_index  <= ram_addr;
        s1_rgb    <= ram_rdata;
`ifdef LED_BRIGHTNESS_SCALE_EN
        s1_bright <= brightness;
`endif
      end
    end
  end

  always_comb begin
`ifdef LED_BRIGHTNESS_SCALE_EN
    grb = {scale(s1_rgb[15:8], s1_bright), scale(s1_rgb[23:16], s1_bright),
           scale(s1_rgb[7:0], s1_bright)};
`else
    grb = {s1_rgb[15:8], s1_rgb[23:16], s1_rgb[7:0]};
`endif
  end

  always_ff @(posedge led_clock or posedge led_counter_reset) begin
    if (led_counter_reset) begin
      pixel_data  <= '0;
      pixel_valid <= 1'b0;
      pixel_index <= '0;
      frame_done  <= 1'b0;
      pixel_count <= '0;
    end else begin
      pixel_valid <= s1_valid;
      frame_done  <= s1_valid && (s1_index == '0);
      if (s1_valid) begin
        pixel_data  <= grb;
        pixel_index <= s1_index;
        if (pixel_count != '1) pixel_count <= pixel_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_led_pixel_fetch.sv
// Directed self-checking bench for led_pixel_fetch; RAM model returns {idx,~idx,0x55}
// unless a fixed word is selected for the brightness checks.
module tb_led_pixel_fetch;

  logic        led_clock = 1'b0;
  logic        led_counter_reset = 1'b0;
  logic [7:0]  led_counter = '0;
  logic        index_valid = 1'b0;
  logic [7:0]  ram_addr;
  logic [23:0] ram_rdata;
  logic [7:0]  brightness = 8'd255;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic [7:0]  pixel_index;
  logic        frame_done;
  logic [7:0]  pixel_count;
  logic        seq_error;
  logic        range_error;

  logic        use_fixed = 1'b0;
  logic [23:0] fixed_word = '0;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 led_clock = ~led_clock;

  always_comb ram_rdata = use_fixed ? fixed_word : {ram_addr, ~ram_addr, 8'h55};

  led_pixel_fetch #(.NUM_LEDS(150), .ADDR_WIDTH(8)) dut (
    .led_clock(led_clock),
    .led_counter_reset(led_counter_reset),
    .led_counter(led_counter),
    .index_valid(index_valid),
    .ram_addr(ram_addr),
    .ram_rdata(ram_rdata),
`ifdef LED_BRIGHTNESS_SCALE_EN
    .brightness(brightness),
`endif
    .pixel_data(pixel_data),
    .pixel_valid(pixel_valid),
    .pixel_index(pixel_index),
    .frame_done(frame_done),
    .pixel_count(pixel_count),
    .seq_error(seq_error),
    .range_error(range_error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge led_clock);
    #1;
  endtask

  // One clock; then check whether a pixel for exp_idx (default RAM pattern) is emitted.
  task automatic tick_expect(input bit exp_valid, input logic [7:0] exp_idx);
    logic [7:0] inv;
    tick();
    inv = ~exp_idx;
    check("pixel_valid", {31'd0, pixel_valid}, {31'd0, exp_valid});
    if (exp_valid) begin
      check("pixel_index", {24'd0, pixel_index}, {24'd0, exp_idx});
      check("pixel_data", {8'd0, pixel_data}, {8'd0, inv, exp_idx, 8'h55});
      check("frame_done", {31'd0, frame_done}, {31'd0, exp_idx == 8'd0});
    end else begin
      check("frame_done_idle", {31'd0, frame_done}, 32'd0);
    end
  endtask

  task automatic do_reset();
    index_valid = 1'b0;
    led_counter_reset = 1'b1;
    #1;
    check("rst_ram_addr", {24'd0, ram_addr}, 32'd0);
    check("rst_pixel_data", {8'd0, pixel_data}, 32'd0);
    check("rst_flags", {28'd0, pixel_valid, frame_done, seq_error, range_error}, 32'd0);
    check("rst_index_count", {16'd0, pixel_index, pixel_count}, 32'd0);
    tick();
    led_counter_reset = 1'b0;
  endtask

  initial begin
    // Full frame 149..0
    do_reset();
    index_valid = 1'b1;
    for (int k = 0; k < 150; k++) begin
      led_counter = 8'(149 - k);
      tick_expect(k >= 2, 8'(151 - k));
      if (k == 0) check("ram_addr_first", {24'd0, ram_addr}, 32'd149);
    end
    // Index 0 held after the frame: drain two, then nothing
    led_counter = 8'd0;
    tick_expect(1'b1, 8'd1);
    tick_expect(1'b1, 8'd0);
    for (int k = 0; k < 5; k++) tick_expect(1'b0, 8'd0);
    check("frame_count", {24'd0, pixel_count}, 32'd150);
    check("frame_seq_err", {31'd0, seq_error}, 32'd0);
    check("frame_range_err", {31'd0, range_error}, 32'd0);
    check("hold_pixel_data", {8'd0, pixel_data}, 32'hFF0055);
    check("hold_pixel_index", {24'd0, pixel_index}, 32'd0);

    // Sequence 10,9,7
    do_reset();
    index_valid = 1'b1;
    led_counter = 8'd10; tick_expect(1'b0, 8'd0);
    led_counter = 8'd9;  tick_expect(1'b0, 8'd0);
    check("seq_ok_after_9", {31'd0, seq_error}, 32'd0);
    led_counter = 8'd7;  tick_expect(1'b1, 8'd10);
    check("seq_err_after_7", {31'd0, seq_error}, 32'd1);
    index_valid = 1'b0;
    tick_expect(1'b1, 8'd9);
    tick_expect(1'b1, 8'd7);
    tick_expect(1'b0, 8'd0);
    check("seq_count", {24'd0, pixel_count}, 32'd3);
    check("seq_range_err", {31'd0, range_error}, 32'd0);

    // Out-of-range index
    do_reset();
    index_valid = 1'b1;
    led_counter = 8'd200;
    tick_expect(1'b0, 8'd0);
    check("range_err_set", {31'd0, range_error}, 32'd1);
    index_valid = 1'b0;
    tick_expect(1'b0, 8'd0);
    tick_expect(1'b0, 8'd0);
    check("range_count", {24'd0, pixel_count}, 32'd0);
    check("range_ram_addr", {24'd0, ram_addr}, 32'd0);
    do_reset();
    check("range_err_cleared", {31'd0, range_error}, 32'd0);

    // Reset with index 5 in flight
    index_valid = 1'b1;
    led_counter = 8'd5;
    tick_expect(1'b0, 8'd0);
    check("inflight_ram_addr", {24'd0, ram_addr}, 32'd5);
    do_reset();
    tick_expect(1'b0, 8'd0);
    tick_expect(1'b0, 8'd0);
    check("inflight_count", {24'd0, pixel_count}, 32'd0);
    index_valid = 1'b1;
    led_counter = 8'd149;
    tick_expect(1'b0, 8'd0);
    index_valid = 1'b0;
    tick_expect(1'b0, 8'd0);
    tick_expect(1'b1, 8'd149);
    check("post_rst_seq_err", {31'd0, seq_error}, 32'd0);
    check("post_rst_count", {24'd0, pixel_count}, 32'd1);

`ifdef LED_BRIGHTNESS_SCALE_EN
    // Brightness scaling on RAM word {FF,80,10}
    do_reset();
    use_fixed = 1'b1;
    fixed_word = 24'hFF8010;
    brightness = 8'd127;
    index_valid = 1'b1; led_counter = 8'd100; tick();
    index_valid = 1'b0; tick(); tick();
    check("bright127_valid", {31'd0, pixel_valid}, 32'd1);
    check("bright127_data", {8'd0, pixel_data}, 32'h407F08);
    brightness = 8'd255;
    index_valid = 1'b1; led_counter = 8'd99; tick();
    index_valid = 1'b0; tick(); tick();
    check("bright255_data", {8'd0, pixel_data}, 32'h80FF10);
    brightness = 8'd0;
    index_valid = 1'b1; led_counter = 8'd98; tick();
    index_valid = 1'b0; tick(); tick();
    check("bright0_index", {24'd0, pixel_index}, 32'd98);
    check("bright0_data", {8'd0, pixel_data}, 32'd0);
    use_fixed = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/led_pixel_fetch.md
# led_pixel_fetch

Per-LED pixel fetch pipeline directly downstream of the LED selector. For each LED index the selector presents on `led_clock`, the block issues a frame-RAM read, captures the 24-bit RGB word, converts it to GRB wire order, optionally scales it by a global brightness, and presents one registered pixel word to the xx6812 encoder. It also flags the end of a frame and detects malformed index sequences.

## Interface
- `NUM_LEDS`, 150: LEDs per strip; valid indices are 0..NUM_LEDS-1.
- `ADDR_WIDTH`, 8: width of the LED index and RAM address.

- `led_clock`  in  1  pipeline clock, one LED slot per cycle.
- `led_counter_reset`  in  1  reset, asynchronous, active-high; clock `led_clock`.
- `led_counter`  in  ADDR_WIDTH  LED index from the selector; counts down.
- `index_valid`  in  1  index is meaningful this cycle (selector counting enabled).
- `ram_addr`  out  ADDR_WIDTH  frame-RAM read address.
- `ram_rdata`  in  24  RAM word {R[23:16],G[15:8],B[7:0]}; valid one cycle after `ram_addr` changes.
- `brightness`  in  8  global scale; present only with `LED_BRIGHTNESS_SCALE_EN`.
- `pixel_data`  out  24  encoder word {G,R,B}.
- `pixel_valid`  out  1  `pixel_data` holds a new pixel; one-cycle pulse per pixel.
- `pixel_index`  out  ADDR_WIDTH  index belonging to `pixel_data`.
- `frame_done`  out  1  one-cycle pulse coincident with emission of index 0.
- `pixel_count`  out  8  pixels emitted since reset; saturates at 255.
- `seq_error`  out  1  sticky: accepted index was not previous accepted index − 1.
- `range_error`  out  1  sticky: index ≥ NUM_LEDS presented with `index_valid`.

## Operation
- Three registered stages. S0 (accept), S1 (capture), S2 (output). Each stage carries a valid bit and its index.
- Accept rule at each edge: `index_valid`=1, `led_counter` < NUM_LEDS, and (no index accepted since reset, or `led_counter` ≠ last accepted index). On accept: `ram_addr`←`led_counter`, S0 valid←1, last-accepted←`led_counter`.
- Repeat of last accepted index: ignored, no error (selector holds at 0 after its final slot).
- Out-of-range index with `index_valid`=1: not accepted, `range_error`←1.
- Sequence check: on accept, when a previous index exists and `led_counter` ≠ previous − 1 (mod 2^ADDR_WIDTH arithmetic, compare at ADDR_WIDTH bits), `seq_error`←1. The pixel is still fetched.
- S1: `ram_rdata` and `brightness` captured together when S0 valid, so brightness cannot change within a pixel.
- S2: GRB reorder plus optional scaling, registered into `pixel_data`, `pixel_valid`←S1 valid, `pixel_index`←S1 index.
- `frame_done`=1 in the same cycle as `pixel_valid`=1 with `pixel_index`=0.
- `pixel_count` increments on every `pixel_valid`, holds at 255.
- No state machine beyond the pipeline valids and the "index seen" flag.
- `pixel_data`, `pixel_index` and `ram_addr` hold their last value when no new pixel is emitted.

## Timing
- Reset (async, immediate): `ram_addr`=0, `pixel_data`=0, `pixel_valid`=0, `pixel_index`=0, `frame_done`=0, `pixel_count`=0, `seq_error`=0, `range_error`=0, all stage valids=0, "index seen"=0.
- Latency is fixed at 2 edges. An index accepted at edge E0 appears at E2 with `pixel_valid`=1. This holds with or without the macro.
- Throughput: one pixel per `led_clock` cycle, fully pipelined, no stalls.
- Reset mid-frame: in-flight pixels are discarded and not emitted. The next accepted index after reset does not raise `seq_error`.
- `led_counter_reset` pulses once per frame. Errors are therefore per-frame sticky.

## Configuration
- `LED_BRIGHTNESS_SCALE_EN` defined: `brightness` port exists. Each channel c becomes (c × (brightness+1)) >> 8 using a 17-bit product and taking bits [15:8]. brightness=255 is identity; brightness=0 yields 0.
- Undefined: no `brightness` port. Channels pass unmodified; reorder only, same 2-cycle latency.

## Test plan
- Reset, then indices 149..0 with `index_valid`=1, RAM word = {idx,~idx,0x55} -> 150 `pixel_valid` pulses each 2 cycles after accept, `pixel_data`={~idx,idx,0x55}, `frame_done` with index 0, `pixel_count`=150, no errors.
- Index 0 held for 5 extra cycles after the frame -> no further `pixel_valid`, `pixel_count` stays 150, `seq_error`=0.
- Sequence 10,9,7 -> three pixels emitted; `seq_error`=1 after accepting 7; `range_error`=0.
- Index 200 with `index_valid`=1 -> nothing emitted, `range_error`=1; a subsequent reset clears it to 0.
- Reset asserted one cycle after accepting index 5 -> no pixel for 5 emitted; all outputs 0; next index 149 accepted cleanly without `seq_error`.
- With `LED_BRIGHTNESS_SCALE_EN`, RAM {0xFF,0x80,0x10}: brightness=127 -> `pixel_data`={0x40,0x7F,0x08}; brightness=255 -> {0x80,0xFF,0x10}; brightness=0 -> 0.
